// File: rtl/fp_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_normalizer_if
//  Description : Operand / result handshake bundle for fp_normalizer.
//                slave  = normalizer side, master = producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_normalizer_if;
    // Operand channel
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    // Result channel
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] mant_out;
    logic        overflow;
    logic        underflow;

    modport slave (
        input  in_valid, sign_in, exp_in, mant_in, out_ready,
        output in_ready, out_valid, sign_out, exp_out, mant_out, overflow, underflow
    );

    modport master (
        output in_valid, sign_in, exp_in, mant_in, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, mant_out, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fp_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : fp_normalizer
//  Description : Single-precision post-add normalizer. Takes a 25-bit raw
//                mantissa sum (bit 24 carry, bit 23 hidden) with its biased
//                exponent, normalizes by one right shift or repeated left
//                shifts, truncating shifted-out bits, and flags overflow to
//                infinity or underflow to denormal.
//  Options     : FP_NORM_LZC_EN - when defined, the left normalization is
//                done in a single cycle using a leading-zero count instead
//                of one bit per cycle. Results are identical either way.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_normalizer (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fp_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic [24:0] r_mant;
    logic        r_ovf;
    logic        r_unf;

`ifdef FP_NORM_LZC_EN
    // Leading zeros of the 24-bit hidden+fraction field; 24 when all zero.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [4:0] w_lz;
    logic [7:0] w_lz_ext;
    assign w_lz     = lzc24(r_mant[23:0]);
    assign w_lz_ext = {3'b000, w_lz};
`endif

    // Control FSM and datapath: capture, normalize step, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= 8'd0;
            r_mant      <= 25'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_sign     <= bus.sign_in;
                        r_exp      <= bus.exp_in;
                        r_mant     <= bus.mant_in;
                        r_ovf      <= 1'b0;
                        r_unf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_state    <= NORM;
                    end
                end

                NORM: begin
                    if (r_exp == 8'hFF) begin
                        // Inf/NaN exponent: leave operand untouched
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_mant[24]) begin
                        // Carry out of the add: one right shift, LSB truncated
                        if (r_exp == 8'hFE) begin
                            r_exp  <= 8'hFF;
                            r_mant <= 25'd0;
                            r_ovf  <= 1'b1;
                        end else begin
                            r_exp  <= r_exp + 8'd1;
                            r_mant <= r_mant >> 1;
                        end
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_mant == 25'd0) begin
                        // Exact zero result
                        r_exp       <= 8'd0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_mant[23]) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_exp <= 8'd1) begin
                        // Cannot shift further without dropping below exp 1
                        r_exp       <= 8'd0;
                        r_unf       <= 1'b1;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
`ifdef FP_NORM_LZC_EN
                        // Whole left shift at once, clamped at exp 1 (denormal)
                        if (w_lz_ext < r_exp) begin
                            r_mant <= r_mant << w_lz;
                            r_exp  <= r_exp - w_lz_ext;
                        end else begin
                            r_mant <= r_mant << (r_exp - 8'd1);
                            r_exp  <= 8'd0;
                            r_unf  <= 1'b1;
                        end
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`else
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 8'd1;
`endif
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sign_out  = r_sign;
    assign bus.exp_out   = r_exp;
    assign bus.mant_out  = r_mant[22:0];
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_normalizer
//  Description : Directed scoreboard bench for fp_normalizer. The driver
//                pushes hand-computed results into a queue; a negedge
//                monitor pops and compares on each new out_valid, and checks
//                output stability under back-pressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_normalizer;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic        ov;
        logic        un;
        int          lat;
        int          c0;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    exp_t q[$];
    exp_t cur;
    bit   have_cur;
    bit   pend_idle;

    fp_normalizer_if bus ();

    fp_normalizer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare each new result, check hold behaviour and return to idle
    always @(negedge clk) begin
        if (!rst_n) begin
            have_cur  = 1'b0;
            pend_idle = 1'b0;
        end else begin
            if (pend_idle) begin
                chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
                chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
                pend_idle = 1'b0;
            end
            if (bus.out_valid) begin
                if (!have_cur) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: out_valid=1 with no operand pending (t=%0t)", $time);
                    end else begin
                        cur = q.pop_front();
                        have_cur = 1'b1;
                        chk("sign_out", {31'd0, bus.sign_out}, {31'd0, cur.s});
                        chk("exp_out", {24'd0, bus.exp_out}, {24'd0, cur.e});
                        chk("mant_out", {9'd0, bus.mant_out}, {9'd0, cur.m});
                        chk("overflow", {31'd0, bus.overflow}, {31'd0, cur.ov});
                        chk("underflow", {31'd0, bus.underflow}, {31'd0, cur.un});
                        chk("latency", cyc - cur.c0, cur.lat);
                    end
                end else begin
                    chk("hold_exp", {24'd0, bus.exp_out}, {24'd0, cur.e});
                    chk("hold_mant", {9'd0, bus.mant_out}, {9'd0, cur.m});
                    chk("hold_flags", {30'd0, bus.overflow, bus.underflow}, {30'd0, cur.ov, cur.un});
                    chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
                end
                if (bus.out_ready && have_cur) begin
                    have_cur  = 1'b0;
                    pend_idle = 1'b1;
                end
            end
        end
    end

    // Present one operand; k is the number of one-bit left shifts expected.
    task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m,
                         input logic [7:0] xe, input logic [22:0] xm,
                         input logic xov, input logic xun, input int k, input bit push);
        int   n;
        exp_t x;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.sign_in  = s;
        bus.exp_in   = e;
        bus.mant_in  = m;
        bus.in_valid = 1'b1;
        x.s  = s;
        x.e  = xe;
        x.m  = xm;
        x.ov = xov;
        x.un = xun;
`ifdef FP_NORM_LZC_EN
        x.lat = 2;
`else
        x.lat = 2 + k;
`endif
        x.c0 = cyc;
        if (push) q.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || have_cur) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || have_cur) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  n;
        bit  seen;
        cyc           = 0;
        errors        = 0;
        checks        = 0;
        have_cur      = 1'b0;
        pend_idle     = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = 8'd0;
        bus.mant_in   = 25'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {bus.sign_out, bus.exp_out, bus.mant_out}, 32'd0);
        chk("rst_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        //     s     exp    mant_in        exp_out mant_out   ov    un   k
        issue(1'b0, 8'h80, 25'h0800000, 8'h80, 23'h000000, 1'b0, 1'b0, 0,  1'b1); // already normal
        issue(1'b0, 8'h80, 25'h1800000, 8'h81, 23'h400000, 1'b0, 1'b0, 0,  1'b1); // carry
        issue(1'b1, 8'h80, 25'h0000001, 8'h69, 23'h000000, 1'b0, 1'b0, 23, 1'b1); // max shifts
        issue(1'b0, 8'h03, 25'h0000100, 8'h00, 23'h000400, 1'b0, 1'b1, 2,  1'b1); // underflow
        issue(1'b0, 8'hFE, 25'h1000000, 8'hFF, 23'h000000, 1'b1, 1'b0, 0,  1'b1); // overflow
        issue(1'b1, 8'hFF, 25'h0123456, 8'hFF, 23'h123456, 1'b0, 1'b0, 0,  1'b1); // inf/nan pass
        issue(1'b0, 8'h40, 25'h0000000, 8'h00, 23'h000000, 1'b0, 1'b0, 0,  1'b1); // zero
        issue(1'b0, 8'h80, 25'h0500000, 8'h7F, 23'h200000, 1'b0, 1'b0, 1,  1'b1); // one shift
        issue(1'b0, 8'h01, 25'h0000010, 8'h00, 23'h000010, 1'b0, 1'b1, 0,  1'b1); // exp 1
        issue(1'b1, 8'h00, 25'h0400000, 8'h00, 23'h400000, 1'b0, 1'b1, 0,  1'b1); // exp 0
        issue(1'b0, 8'h10, 25'h1FFFFFF, 8'h11, 23'h7FFFFF, 1'b0, 1'b0, 0,  1'b1); // truncation
        issue(1'b0, 8'h02, 25'h0200000, 8'h00, 23'h400000, 1'b0, 1'b1, 1,  1'b1); // shift then uf
        issue(1'b0, 8'hFF, 25'h1000000, 8'hFF, 23'h000000, 1'b0, 1'b0, 0,  1'b1); // 255 beats carry
        drain();

        // Back-pressure: result must hold for 5 cycles, then return to idle
        bus.out_ready = 1'b0;
        issue(1'b1, 8'h7F, 25'h0C00000, 8'h7F, 23'h400000, 1'b0, 1'b0, 0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_still_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        drain();

        // Reset in the middle of a long normalization
        issue(1'b1, 8'h80, 25'h0000001, 8'h69, 23'h000000, 1'b0, 1'b0, 23, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        chk("mid_exp_nonzero", {31'd0, (bus.exp_out != 8'd0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_data", {bus.sign_out, bus.exp_out, bus.mant_out}, 32'd0);
        chk("async_flags", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("no_out_after_reset", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;

        // Next operand after the abandoned one
        issue(1'b0, 8'h85, 25'h0000300, 8'h77, 23'h400000, 1'b0, 1'b0, 14, 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: in_valid  input  1  operand present; in_ready  output  1  block can accept; sign_in  input  1; exp_in  input  8  biased exponent after alignment; mant_in  input  25  raw sum, bit 24 = carry, bit 23 = hidden.
REQ-003 SHALL have ports: out_valid  output  1; out_ready  input  1; sign_out  output  1; exp_out  output  8; mant_out  output  23  fraction, hidden bit dropped; overflow  output  1; underflow  output  1.
REQ-004 SHALL have no parameters; all widths fixed to IEEE-754 single precision.

Function
REQ-005 SHALL implement FSM states IDLE, NORM, DONE.
REQ-006 IDLE: in_ready=1; on in_valid&&in_ready, SHALL register sign/exp/mant, clear flags, go NORM.
REQ-007 NORM, first matching rule per cycle: exp==255 -> pass through unchanged, DONE; mant[24]==1 -> mant>>1, exp+1, DONE; mant==0 -> exp=0, DONE; mant[23]==1 -> DONE; exp<=1 -> exp=0, mant unchanged, underflow=1, DONE; else mant<<1, exp-1, stay NORM.
REQ-008 Right-shift case with exp==254 SHALL yield exp=255, mant=0, overflow=1 (infinity).
REQ-009 Shifted-out bits SHALL be discarded (truncation; no rounding).
REQ-010 DONE: out_valid=1; outputs stable while out_valid&&!out_ready; on out_ready go IDLE.
REQ-011 in_ready SHALL be 0 in NORM and DONE; no new operand accepted until DONE handshake completes.
REQ-012 Latency accept-to-out_valid SHALL be 2 cycles for already-normalized or carry inputs, 2+k cycles for k left shifts (k<=23).
REQ-013 mant_out SHALL equal internal mant[22:0]; sign_out SHALL equal captured sign unchanged.
REQ-014 overflow/underflow SHALL be valid only with out_valid and held until handshake.

Reset
REQ-015 rst_n low SHALL immediately force state IDLE, out_valid=0, in_ready=1 on release, all data outputs and flags 0.
REQ-016 Reset asserted in NORM or DONE SHALL abandon the operation; no out_valid after release.

Configuration
REQ-017 Macro FP_NORM_LZC_EN: when defined, NORM SHALL compute leading-zero count of mant[23:0] and perform the full left shift (clamped so exp stays >=1, else denormal per REQ-007) in one cycle; latency always 2 cycles.
REQ-018 Without FP_NORM_LZC_EN, iterative one-bit-per-cycle behaviour of REQ-007 SHALL apply; results SHALL be bit-identical in both builds.

Verification
REQ-019 exp_in=0x80, mant_in=0x0800000 -> out_valid at cycle 2, exp_out=0x80, mant_out=0, flags 0.
REQ-020 exp_in=0x80, mant_in=0x1800000 -> exp_out=0x81, mant_out=0x400000 after 2 cycles.
REQ-021 exp_in=0x80, mant_in=0x0000001 -> 23 left shifts, exp_out=0x69, mant_out=0, out_valid at cycle 25 (cycle 2 with FP_NORM_LZC_EN).
REQ-022 exp_in=0x03, mant_in=0x0000100 -> underflow=1, exp_out=0; exp_in=0xFE, mant_in=0x1000000 -> overflow=1, exp_out=0xFF, mant_out=0.
REQ-023 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-024 rst_n pulsed low mid-NORM -> outputs zero asynchronously, no out_valid after release, next operand processed correctly.
